// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
// SRAM_CTRL_TURNAROUND_EN adds a one-cycle bus gap after every write.
package sram_ctrl_pkg;

    localparam int WAIT_CNT_W  = $clog2(16);
    localparam int RD_WAIT_MAX = 15;
    localparam int WR_WAIT_MIN = 1;
    localparam int WR_WAIT_MAX = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_WR_HOLD,
        ST_TURN
    } state_e;

    // Byte-offset bits dropped from the CPU address to form the word address.
    function automatic int addr_off(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/sram_ctrl_timer.sv
// Loadable down-counter that stops at zero; done flags the final wait cycle.
module sram_ctrl_timer
    import sram_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_val,
    output logic                  done
);

    logic [WAIT_CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Multi-cycle CPU-to-async-SRAM controller with registered strobes.
// Optional SRAM_CTRL_TURNAROUND_EN inserts a TURN cycle after writes.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 20,
    parameter int CPU_ADDR_W = 32,
    parameter int RD_WAIT    = 1,
    parameter int WR_WAIT    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic [DATA_W/8-1:0]   cpu_we,
    input  logic [CPU_ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic                  cpu_addr_ok,
    output logic                  cpu_data_ok,
    output logic [DATA_W-1:0]     cpu_rdata,
    inout  wire  [DATA_W-1:0]     ram_data,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W/8-1:0]   ram_be_n,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n
);

    localparam int BE_W = DATA_W / 8;
    localparam int OFF  = addr_off(DATA_W);

    localparam logic [WAIT_CNT_W-1:0] RD_LOAD = WAIT_CNT_W'(RD_WAIT);
    localparam logic [WAIT_CNT_W-1:0] WR_LOAD = WAIT_CNT_W'(WR_WAIT - 1);

    if ((DATA_W % 8) != 0 || RD_WAIT < 0 || RD_WAIT > RD_WAIT_MAX ||
        WR_WAIT < WR_WAIT_MIN || WR_WAIT > WR_WAIT_MAX ||
        CPU_ADDR_W < ADDR_W + OFF) begin : g_bad_param
        $error("sram_ctrl: parameter out of range");
    end

    state_e state;
    state_e state_d;

    logic                  tmr_load;
    logic [WAIT_CNT_W-1:0] tmr_val;
    logic                  tmr_done;
    logic                  capture;
    logic                  ok_d;
    logic                  accept;
    logic                  is_wr;

    logic [BE_W-1:0]   we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              drive_q;
    logic [BE_W-1:0]   be_src;

    logic nxt_rd;
    logic nxt_wr;
    logic nxt_hold;
    logic unused_addr;

    assign accept      = (state == ST_IDLE) & cpu_req & ~reset;
    assign cpu_addr_ok = accept;
    assign is_wr       = |cpu_we;
    assign unused_addr = ^cpu_addr;

    sram_ctrl_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        capture  = 1'b0;
        ok_d     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    tmr_load = 1'b1;
                    if (is_wr) begin
                        state_d = ST_WRITE;
                        tmr_val = WR_LOAD;
                    end else begin
                        state_d = ST_READ;
                        tmr_val = RD_LOAD;
                    end
                end
            end
            ST_READ: begin
                if (tmr_done) begin
                    capture = 1'b1;
                    ok_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (tmr_done) begin
                    state_d = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD: begin
                ok_d = 1'b1;
`ifdef SRAM_CTRL_TURNAROUND_EN
                state_d = ST_TURN;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef SRAM_CTRL_TURNAROUND_EN
            ST_TURN: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state so they change only on edges.
    assign nxt_rd   = (state_d == ST_READ);
    assign nxt_wr   = (state_d == ST_WRITE);
    assign nxt_hold = (state_d == ST_WR_HOLD);
    assign be_src   = (state == ST_IDLE) ? cpu_we : we_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_be_n    <= '1;
            ram_addr    <= '0;
            drive_q     <= 1'b0;
            we_q        <= '0;
            wdata_q     <= '0;
            cpu_rdata   <= '0;
            cpu_data_ok <= 1'b0;
        end else begin
            ram_ce_n    <= ~(nxt_rd | nxt_wr | nxt_hold);
            ram_oe_n    <= ~nxt_rd;
            ram_we_n    <= ~nxt_wr;
            drive_q     <= nxt_wr | nxt_hold;
            cpu_data_ok <= ok_d;
            if (nxt_rd) begin
                ram_be_n <= '0;
            end else if (nxt_wr | nxt_hold) begin
                ram_be_n <= ~be_src;
            end else begin
                ram_be_n <= '1;
            end
            if (accept) begin
                ram_addr <= cpu_addr[ADDR_W+OFF-1:OFF];
                we_q     <= cpu_we;
                wdata_q  <= cpu_wdata;
            end
            if (capture) begin
                cpu_rdata <= ram_data;
            end
        end
    end

    assign ram_data = drive_q ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench: 32-bit controller (RD_WAIT=1, WR_WAIT=2) plus a 16-bit
// controller (RD_WAIT=0, WR_WAIT=1), each with a behavioural SRAM model.
module tb_sram_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        cpu_req;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    wire  [31:0] ram_data;
    logic [19:0] ram_addr;
    logic [3:0]  be_n;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;

    logic        b_req;
    logic [1:0]  b_we;
    logic [31:0] b_addr;
    logic [15:0] b_wdata;
    logic        b_addr_ok;
    logic        b_data_ok;
    logic [15:0] b_rdata;
    wire  [15:0] b_ram_data;
    logic [19:0] b_ram_addr;
    logic [1:0]  b_be_n;
    logic        b_ce_n;
    logic        b_oe_n;
    logic        b_we_n;

    int total = 0;
    int bad   = 0;

    sram_ctrl #(
        .DATA_W(32), .ADDR_W(20), .CPU_ADDR_W(32), .RD_WAIT(1), .WR_WAIT(2)
    ) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_addr_ok(addr_ok), .cpu_data_ok(data_ok),
        .cpu_rdata(rdata), .ram_data(ram_data), .ram_addr(ram_addr),
        .ram_be_n(be_n), .ram_ce_n(ce_n), .ram_oe_n(oe_n), .ram_we_n(we_n)
    );

    sram_ctrl #(
        .DATA_W(16), .ADDR_W(20), .CPU_ADDR_W(32), .RD_WAIT(0), .WR_WAIT(1)
    ) u_dut16 (
        .clk(clk), .reset(reset),
        .cpu_req(b_req), .cpu_we(b_we), .cpu_addr(b_addr),
        .cpu_wdata(b_wdata), .cpu_addr_ok(b_addr_ok), .cpu_data_ok(b_data_ok),
        .cpu_rdata(b_rdata), .ram_data(b_ram_data), .ram_addr(b_ram_addr),
        .ram_be_n(b_be_n), .ram_ce_n(b_ce_n), .ram_oe_n(b_oe_n), .ram_we_n(b_we_n)
    );

    logic [31:0] mem   [0:255];
    logic [15:0] mem16 [0:255];

    assign ram_data   = (!ce_n && !oe_n) ? mem[ram_addr[7:0]] : 'z;
    assign b_ram_data = (!b_ce_n && !b_oe_n) ? mem16[b_ram_addr[7:0]] : 'z;

    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!be_n[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_data[b*8 +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wd, output int acc_wait,
                        output int lat, output int oe_c, output int we_c,
                        output int hold_c, output int bad_drv,
                        output logic [3:0] be_seen);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        #1;
        acc_wait = 0;
        while (!addr_ok && acc_wait < 10) begin
            tick();
            acc_wait++;
        end
        tick();
        cpu_req = 1'b0;
        cpu_we  = '0;
        lat = 1; oe_c = 0; we_c = 0; hold_c = 0; bad_drv = 0;
        be_seen = 4'hF;
        while (!data_ok && lat < 20) begin
            if (!oe_n) oe_c++;
            if (!we_n) we_c++;
            if (!ce_n) be_seen = be_n;
            if (!ce_n && we_n && oe_n) hold_c++;
            if (!ce_n && oe_n && ram_data !== wd) bad_drv++;
            tick();
            lat++;
        end
    endtask

    int aw, lat, oe_c, we_c, hold_c, bdrv, okc;
    logic [3:0] be_seen;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 32'h0;
            mem16[i] = 16'h0;
        end
        mem[4]   = 32'hDEADBEEF;
        mem[8]   = 32'h11223344;
        mem16[1] = 16'hBEEF;

        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
        b_req = 1'b0; b_we = '0; b_addr = '0; b_wdata = '0;
        tick(); tick();
        check("rst_ce_n", ce_n, 1);
        check("rst_oe_n", oe_n, 1);
        check("rst_we_n", we_n, 1);
        check("rst_be_n", be_n, 4'hF);
        check("rst_addr", ram_addr, 0);
        check("rst_rdata", rdata, 0);
        check("rst_data_ok", data_ok, 0);
        check("rst_addr_ok", addr_ok, 0);
        cpu_req = 1'b0;
        reset = 1'b0;
        tick();

        xfer(4'b0000, 32'h10, 32'h0, aw, lat, oe_c, we_c, hold_c, bdrv, be_seen);
        check("rd_accept_wait", aw, 0);
        check("rd_addr", ram_addr, 20'h00004);
        check("rd_oe_cycles", oe_c, 2);
        check("rd_be_n", be_seen, 4'h0);
        check("rd_latency", lat, 3);
        check("rd_data", rdata, 32'hDEADBEEF);
        tick();
        check("rd_ok_pulse", data_ok, 0);
        check("idle_ce_n", ce_n, 1);

        xfer(4'b0100, 32'h20, 32'h00AB0000, aw, lat, oe_c, we_c, hold_c, bdrv,
             be_seen);
        check("wr_be_n", be_seen, 4'b1011);
        check("wr_we_cycles", we_c, 2);
        check("wr_hold_cycles", hold_c, 1);
        check("wr_oe_cycles", oe_c, 0);
        check("wr_bus_data", bdrv, 0);
        check("wr_latency", lat, 4);
        check("wr_mem", mem[8], 32'h11AB3344);
        tick();

        xfer(4'b1111, 32'h40, 32'h12345678, aw, lat, oe_c, we_c, hold_c, bdrv,
             be_seen);
        check("b2b_wr_latency", lat, 4);
        check("b2b_wr_mem", mem[16], 32'h12345678);
        xfer(4'b0000, 32'h40, 32'h0, aw, lat, oe_c, we_c, hold_c, bdrv, be_seen);
`ifdef SRAM_CTRL_TURNAROUND_EN
        check("b2b_accept_wait", aw, 1);
`else
        check("b2b_accept_wait", aw, 0);
`endif
        check("b2b_rd_latency", lat, 3);
        check("b2b_rd_data", rdata, 32'h12345678);
        tick();

        cpu_req = 1'b1; cpu_we = '0; cpu_addr = 32'h10;
        #1;
        check("mid_addr_ok", addr_ok, 1);
        tick();
        cpu_req = 1'b0;
        tick();
        check("mid_oe_before", oe_n, 0);
        reset = 1'b1;
        cpu_req = 1'b1;
        #1;
        check("mid_ce_n", ce_n, 1);
        check("mid_oe_n", oe_n, 1);
        check("mid_be_n", be_n, 4'hF);
        check("mid_addr", ram_addr, 0);
        check("mid_rdata", rdata, 0);
        check("mid_addr_ok_rst", addr_ok, 0);
        okc = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (data_ok) okc++;
        end
        reset = 1'b0;
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (data_ok) okc++;
        end
        check("mid_no_data_ok", okc, 0);
        xfer(4'b0000, 32'h10, 32'h0, aw, lat, oe_c, we_c, hold_c, bdrv, be_seen);
        check("post_rst_latency", lat, 3);
        check("post_rst_data", rdata, 32'hDEADBEEF);
        tick();

        b_req = 1'b1; b_we = '0; b_addr = 32'h2;
        #1;
        check("w16_addr_ok", b_addr_ok, 1);
        tick();
        b_req = 1'b0;
        check("w16_addr", b_ram_addr, 20'h00001);
        check("w16_be_n", b_be_n, 2'b00);
        check("w16_oe_n", b_oe_n, 0);
        lat = 1;
        while (!b_data_ok && lat < 20) begin
            tick();
            lat++;
        end
        check("w16_latency", lat, 2);
        check("w16_data", b_rdata, 16'hBEEF);
        check("w16_oe_after", b_oe_n, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
